// File: rtl/sipo_piso_pkg.sv
// rtl/sipo_piso_pkg.sv - shared state and bit-order types for the piso_reg/sipo_reg serial link
package sipo_piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } piso_state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

endpackage

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - loadable down-counter with zero flag; decrement holds at zero
module piso_bit_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_reg.sv
// rtl/piso_reg.sv - parallel-in serial-out transmitter; PISO_PARITY_EN appends an even-parity bit
module piso_reg
    import sipo_piso_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  shift_dir,
    output logic                  serial_out,
    output logic                  serial_we,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    piso_state_e           r_state;
    piso_state_e           w_next;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_dir;
    logic                  w_accept;
    logic                  w_zero;
    logic                  w_bit;

    assign w_accept = load_valid && (r_state == IDLE);

    piso_bit_cnt #(.W(CW)) u_bit_cnt (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_load     (w_accept),
        .i_load_val (LAST_IDX),
        .i_dec      (r_state == SHIFT),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SHIFT;
            SHIFT:   if (w_zero)   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Vacated bits fill with zero so the register is clean once the frame drains.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_shreg <= '0;
            r_dir   <= DIR_RIGHT;
        end else if (w_accept) begin
            r_shreg <= parallel_in;
            r_dir   <= shift_dir;
        end else if (r_state == SHIFT) begin
            if (r_dir == DIR_LEFT) begin
                r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
            end else begin
                r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
            end
        end
    end

`ifdef PISO_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^parallel_in;
        end
    end

    // Counter at zero marks the trailing parity slot, after all data bits.
    assign w_bit = w_zero ? r_parity
                 : ((r_dir == DIR_LEFT) ? r_shreg[DATA_WIDTH-1] : r_shreg[0]);
`else
    assign w_bit = (r_dir == DIR_LEFT) ? r_shreg[DATA_WIDTH-1] : r_shreg[0];
`endif

    assign serial_we  = (r_state == SHIFT);
    assign serial_out = serial_we & w_bit;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign load_ready = (r_state == IDLE);

endmodule

// File: tb/tb_piso_reg.sv
// tb/tb_piso_reg.sv - randomized and directed bench for piso_reg against a frame-timing model
module tb_piso_reg;

    localparam int DW = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = DW + 1;
    localparam logic [15:0] EXP_1E_L = 16'h003C;
    localparam logic [15:0] EXP_1E_R = 16'h00F0;
    localparam logic [15:0] EXP_1F_L = 16'h003F;
`else
    localparam int FL = DW;
    localparam logic [15:0] EXP_1E_L = 16'h001E;
    localparam logic [15:0] EXP_1E_R = 16'h0078;
    localparam logic [15:0] EXP_1F_L = 16'h001F;
`endif

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          shift_dir = 1'b0;
    logic [DW-1:0] parallel_in = '0;
    logic          load_ready;
    logic          serial_out;
    logic          serial_we;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    piso_reg #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .parallel_in (parallel_in),
        .shift_dir   (shift_dir),
        .serial_out  (serial_out),
        .serial_we   (serial_we),
        .busy        (busy),
        .done        (done)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            m_t0 = -1000;
    logic [DW-1:0] m_word = '0;
    logic          m_dir = 1'b0;
    bit            chk_en = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic checkv(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_frame(input int c, input int t0);
        int k;
        k = c - t0 - 1;
        return (k >= 0) && (k <= FL);
    endfunction

    function automatic logic frame_bit(input int k);
        if (k == DW) return ^m_word;
        return m_dir ? m_word[DW-1-k] : m_word[k];
    endfunction

    // Model: a frame is just "the word accepted at edge t0"; everything follows from c - t0.
    always @(posedge clk) begin
        if (!arst_n) begin
            m_t0 = -1000;
            chk_en = 1'b1;
        end else if (load_valid && !in_frame(cyc, m_t0)) begin
            m_t0 = cyc;
            m_word = parallel_in;
            m_dir = shift_dir;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int   k;
        logic we_e;
        if (chk_en) begin
            k = cyc - m_t0 - 1;
            we_e = (k >= 0) && (k < FL);
            check1("load_ready", load_ready, !in_frame(cyc, m_t0));
            check1("busy", busy, in_frame(cyc, m_t0));
            check1("done", done, k == FL);
            check1("serial_we", serial_we, we_e);
            check1("serial_out", serial_out, we_e ? frame_bit(k) : 1'b0);
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (load_ready) ok = 1'b1;
        end
        if (!ok) checkv("wait_ready_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [DW-1:0] w, input logic d, input bit hold,
                             input logic [15:0] exp_stream);
        logic [15:0] stream;
        int          n;
        int          done_j;
        logic        rdy;
        wait_ready();
        parallel_in = w;
        shift_dir = d;
        load_valid = 1'b1;
        @(negedge clk);
        if (hold) parallel_in = 8'hFF;
        else load_valid = 1'b0;
        stream = '0;
        n = 0;
        done_j = 0;
        rdy = 1'b0;
        for (int j = 1; j <= FL + 2; j++) begin
            if (serial_we) begin
                stream = {stream[14:0], serial_out};
                n++;
            end
            if (done && done_j == 0) done_j = j;
            if (j == FL + 2) rdy = load_ready;
            if (j < FL + 2) @(negedge clk);
        end
        checkv("frame_stream", int'(stream), int'(exp_stream));
        checkv("frame_len", n, FL);
        checkv("done_offset", done_j, FL + 1);
        check1("ready_back", rdy, 1'b1);
    endtask

    initial begin
        int dn;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        check1("rst_ready", load_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_we", serial_we, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_sout", serial_out, 1'b0);

        run_frame(8'h1E, 1'b1, 1'b0, EXP_1E_L);
        run_frame(8'h1E, 1'b0, 1'b0, EXP_1E_R);
        run_frame(8'h1F, 1'b1, 1'b0, EXP_1F_L);

        // Valid held high through the frame: 0xFF must be taken only on return to idle.
        run_frame(8'h1E, 1'b1, 1'b1, EXP_1E_L);
        @(negedge clk);
        load_valid = 1'b0;
        check1("hold_we", serial_we, 1'b1);
        check1("hold_bit0", serial_out, 1'b1);

        // Mid-frame reset after three bits.
        wait_ready();
        parallel_in = 8'h1E;
        shift_dir = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        check1("abort_we", serial_we, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_ready", load_ready, 1'b1);
        dn = 0;
        for (int i = 0; i < FL + 4; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checkv("abort_no_done", dn, 0);

        for (int i = 0; i < 3000; i++) begin
            load_valid = ($urandom % 3) != 0;
            parallel_in = DW'($urandom);
            shift_dir = 1'($urandom);
            arst_n = ($urandom % 80) != 0;
            @(negedge clk);
        end
        arst_n = 1'b1;
        load_valid = 1'b0;
        repeat (FL + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_reg.md
# piso_reg

Parallel-in serial-out transmitter: the sending end of the serial link consumed by `sipo_reg`. It accepts a `DATA_WIDTH`-bit word over a valid/ready load handshake and shifts it out one bit per clock. During the frame it drives a write-enable strobe intended to connect directly to the `sipo_reg` `we` input. If both ends use the same `shift_dir`, the receiver reconstructs the original word.

## Interface
- `DATA_WIDTH`, 32, word width in bits; must be ≥ 2.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `arst_n` input 1: reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `load_valid` input 1: `parallel_in` holds a word to transmit.
- `load_ready` output 1: block can accept a word; high only in IDLE.
- `parallel_in` input DATA_WIDTH: word to transmit; sampled only on an accepted load.
- `shift_dir` input 1: bit order. 1 sends MSB first (pairs with receiver shift-left); 0 sends LSB first (pairs with receiver shift-right). Sampled only on an accepted load.
- `serial_out` output 1: current serial bit.
- `serial_we` output 1: high exactly while `serial_out` carries a frame bit; drives receiver `we`.
- `busy` output 1: high in SHIFT and DONE.
- `done` output 1: one-cycle pulse after the last frame bit.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `load_ready`=1.
  - On an edge with `load_valid`&&`load_ready`: capture `parallel_in` into the shift register and `shift_dir` into a direction flag, load the bit counter with FRAME_LEN-1, go to SHIFT.
- **SHIFT**
  - `serial_we`=1.
  - `serial_out` = MSB of the shift register if the direction flag is 1, else its LSB.
  - Each edge: shift the register left (flag 1) or right (flag 0), zero-filling the vacated bit, and decrement the counter.
  - At counter 0: go to DONE.
- **DONE**
  - `serial_we`=0, `done`=1, `load_ready`=0.
  - Next edge: go to IDLE unconditionally.
- Frame length: FRAME_LEN = `DATA_WIDTH`, or `DATA_WIDTH`+1 with parity (see Configuration).
- Counter width: `$clog2(DATA_WIDTH+1)`. The counter never wraps; the decrement is gated at 0.
- Outside an accepted handshake, changes on `load_valid`, `parallel_in` and `shift_dir` are ignored, including while busy. No load is queued.
- Reset (`arst_n` low on an edge), valid in any state including mid-frame:
  - state IDLE;
  - shift register, counter, `serial_out`, `serial_we`, `busy`, `done` all 0;
  - `load_ready`=1;
  - the partial frame is abandoned and no `done` is issued.
- `arst_n` low has priority over an accepted load on the same edge.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Load accepted on edge T0:
  - frame bit k appears on `serial_out` with `serial_we`=1 during cycle T0+1+k, for k = 0..FRAME_LEN-1;
  - `done` is high during cycle T0+FRAME_LEN+1;
  - `load_ready` returns high in cycle T0+FRAME_LEN+2.
- Minimum load-to-load spacing: FRAME_LEN+2 cycles.
- The DONE cycle guarantees the receiver sees `we`=0 for at least one edge, so it registers `parallel_out`. Receiver output is valid in cycle T0+FRAME_LEN+2.

## Configuration
- Macro: `PISO_PARITY_EN`.
  - Defined: after the data bits, one extra SHIFT cycle sends the even-parity bit, equal to the XOR reduction of the captured word, with `serial_we`=1. FRAME_LEN = `DATA_WIDTH`+1.
  - Undefined: no parity logic. FRAME_LEN = `DATA_WIDTH`.
  - Note: with parity enabled, the receiver's last shifted-in bit is the parity bit.

## Structure
- Shared package `sipo_piso_pkg`:
  - `piso_state_e` enum (IDLE, SHIFT, DONE);
  - a `dir_e` constant pair (DIR_RIGHT=0, DIR_LEFT=1), also usable by `sipo_reg` benches.
- One sub-module, `piso_bit_cnt`: a loadable down-counter with zero flag, parameterised on width. Everything else stays in `piso_reg`.

## Test plan
1. DATA_WIDTH=8, load 0x1E with `shift_dir`=1 → `serial_out` 0,0,0,1,1,1,1,0 over cycles T0+1..T0+8 with `serial_we`=1; `done`=1 at T0+9; `load_ready`=1 at T0+10.
2. Same word with `shift_dir`=0 → `serial_out` 0,1,1,1,1,0,0,0.
3. Hold `load_valid`=1 with 0xFF throughout the frame of 0x1E → `load_ready`=0 while busy, serial stream unchanged; 0xFF accepted only at T0+10.
4. Assert `arst_n`=0 for one edge after 3 bits → next cycle `serial_we`=0, `busy`=0, `load_ready`=1, and `done` never pulses.
5. Loopback into `sipo_reg`, DATA_WIDTH=32, word 0xDEADBEEF, both `shift_dir`=1, receiver `out_dir`=0 → receiver `parallel_out`=0xDEADBEEF in cycle T0+34. Repeat with `shift_dir`=0 on both ends for the same result.
6. `PISO_PARITY_EN` defined, DATA_WIDTH=8 → 0x1E gives 9th bit 0; 0x1F gives 9th bit 1; `done` at T0+10.
